pulse_seq_gen: RTL and testbench

//   Clocked generator for the two-input pulse protocol on x1/x2. Plays back a

---
 rtl/pulse_seq_gen.sv | 95 +++++++++
 tb/tb_pulse_seq_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pulse_seq_gen.sv
// pulse_seq_gen: plays a latched symbol string as non-overlapping x1/x2 pulses separated by idle gaps.
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   begin playback, sampled only in IDLE
//   abort    in   synchronous cancel of playback in progress
//   seq_bits in   symbols, bit0 first; 1 = x1 pulse, 0 = x2 pulse
//   seq_len  in   symbol count, clamped to MAX_LEN
//   x1, x2   out  registered protocol lines
//   busy     out  high from start acceptance until playback ends
//   done     out  one-cycle pulse after the last trailing gap
//   sym_idx  out  index of the current symbol
module pulse_seq_gen #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 3,
  parameter int MAX_LEN      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] seq_bits,
  input  logic [4:0]         seq_len,
  output logic               x1,
  output logic               x2,
  output logic               busy,
  output logic               done,
  output logic [4:0]         sym_idx
);
  localparam int CMAX = PULSE_CYCLES > GAP_CYCLES ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;
  typedef enum logic [2:0] {IDLE, LEAD, PULSE, GAP, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0] idx_n, len, len_n, clamp;
  logic [MAX_LEN-1:0] bits, bits_n, sh;
  logic last_p, last_g;
  assign clamp  = seq_len > 5'(MAX_LEN) ? 5'(MAX_LEN) : seq_len;
  assign last_p = cnt == CW'(PULSE_CYCLES - 1);
  assign last_g = cnt == CW'(GAP_CYCLES - 1);
  assign sh     = bits_n >> idx_n;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = sym_idx;
    len_n   = len;
    bits_n  = bits;
    case (state)
      IDLE: if (start && !abort) begin
        state_n = LEAD;
        bits_n  = seq_bits;
        len_n   = clamp;
        idx_n   = '0;
        // an empty string spends a single busy cycle in LEAD before DONE
        cnt_n   = clamp == 5'd0 ? CW'(GAP_CYCLES - 1) : '0;
      end
      LEAD: begin
        state_n = abort ? IDLE : last_g ? (len == 5'd0 ? DONE : PULSE) : LEAD;
        cnt_n   = abort || last_g ? '0 : cnt + 1'b1;
      end
      PULSE: begin
        state_n = abort ? IDLE : last_p ? GAP : PULSE;
        cnt_n   = abort || last_p ? '0 : cnt + 1'b1;
        idx_n   = abort ? '0 : sym_idx;
      end
      GAP: begin
        state_n = abort ? IDLE : !last_g ? GAP : sym_idx + 5'd1 < len ? PULSE : DONE;
        cnt_n   = abort || last_g ? '0 : cnt + 1'b1;
        idx_n   = abort ? '0 : !last_g ? sym_idx : sym_idx + 5'd1 < len ? sym_idx + 5'd1 : '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sym_idx <= '0;
      len     <= '0;
      bits    <= '0;
      x1      <= 1'b0;
      x2      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sym_idx <= idx_n;
      len     <= len_n;
      bits    <= bits_n;
      x1      <= state_n == PULSE && sh[0];
      x2      <= state_n == PULSE && !sh[0];
      busy    <= state_n inside {LEAD, PULSE, GAP};
      done    <= state_n == DONE;
    end
endmodule

// File: tb/tb_pulse_seq_gen.sv
// tb_pulse_seq_gen: table-driven playback vectors checked cycle by cycle through an expected-output queue.
module tb_pulse_seq_gen;
  localparam int P = 2;
  localparam int G = 3;
  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic [15:0] seq_bits = '0;
  logic [4:0] seq_len = '0;
  logic x1, x2, busy, done;
  logic [4:0] sym_idx;
  int checks = 0, errors = 0;
  int x1c = 0, x2c = 0, dc = 0;
  logic px1 = 0, px2 = 0;

  typedef struct packed {logic x1, x2, busy, done; logic [4:0] idx;} exp_t;
  exp_t q[$];

  typedef struct {
    logic [15:0] bits;
    int len, ab, smid, ex1, ex2, edone;
  } vec_t;

  pulse_seq_gen #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .MAX_LEN(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seq_bits(seq_bits),
    .seq_len(seq_len), .x1(x1), .x2(x2), .busy(busy), .done(done), .sym_idx(sym_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) chk("no_overlap", {31'd0, x1 && x2}, 0);
    x1c += int'(x1 && !px1);
    x2c += int'(x2 && !px2);
    dc  += int'(done);
    px1 = x1;
    px2 = x2;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("trace", {23'd0, x1, x2, busy, done, sym_idx}, {23'd0, e});
    end
  end

  task automatic push_trace(input logic [15:0] b, input int len, input int ab);
    int n, t;
    n = len > 16 ? 16 : len;
    t = n == 0 ? 1 : G + n * (P + G);
    for (int j = 0; j <= t + 1; j++) begin
      exp_t e;
      e = '0;
      if (ab > 0 && j >= ab) e = '0;
      else if (j < t) begin
        e.busy = 1;
        if (n > 0 && j >= G) begin
          int m, i;
          m = j - G;
          i = m / (P + G);
          e.idx = 5'(i);
          if (m % (P + G) < P) begin
            e.x1 = b[i];
            e.x2 = !b[i];
          end
        end
      end else if (j == t) e.done = 1;
      q.push_back(e);
    end
  endtask

  task automatic play(input vec_t v);
    bit ok;
    @(posedge clk);
    #2;
    x1c = 0; x2c = 0; dc = 0;
    seq_bits = v.bits;
    seq_len = 5'(v.len);
    start = 1;
    push_trace(v.bits, v.len, v.ab);
    ok = 0;
    for (int j = 0; j < 300; j++) begin
      @(posedge clk);
      #2;
      if (q.size() == 0) begin
        ok = 1;
        break;
      end
      start = v.smid > 0 && j + 1 == v.smid;
      abort = v.ab > 0 && j + 1 == v.ab;
      seq_bits = 16'($urandom);
      seq_len = 5'($urandom);
    end
    start = 0;
    abort = 0;
    chk("timeout", {31'd0, ok}, 1);
    q.delete();
    chk("x1_pulses", x1c, v.ex1);
    chk("x2_pulses", x2c, v.ex2);
    chk("done_count", dc, v.edone);
  endtask

  task automatic reset_mid(input int j, input logic exp_x1);
    @(posedge clk);
    #2;
    seq_bits = 16'h0003;
    seq_len = 5'd2;
    start = 1;
    @(posedge clk);
    #2;
    start = 0;
    repeat (j) @(posedge clk);
    #2;
    chk("pre_rst_busy", {31'd0, busy}, 1);
    chk("pre_rst_x1", {31'd0, x1}, {31'd0, exp_x1});
    rst = 1;
    #1;
    chk("rst_async", {27'd0, x1, x2, busy, done, sym_idx[0]}, 0);
    chk("rst_idx", {27'd0, sym_idx}, 0);
    #2;
    rst = 0;
    @(posedge clk);
    #2;
    chk("post_rst_idle", {28'd0, x1, x2, busy, done}, 0);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{16'b01, 2, 0, 0, 1, 1, 1});
    vecs.push_back('{16'h0000, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{16'hFFFF, 20, 0, 0, 16, 0, 1});
    vecs.push_back('{16'b010001, 6, 0, 0, 2, 4, 1});
    vecs.push_back('{16'b01, 2, 9, 0, 1, 1, 0});
    vecs.push_back('{16'b01, 2, 0, 0, 1, 1, 1});
    vecs.push_back('{16'b101, 3, 0, 5, 2, 1, 1});
    vecs.push_back('{16'b1, 4, 1, 0, 0, 0, 0});
    vecs.push_back('{16'b0, 1, 0, 0, 0, 1, 1});
    vecs.push_back('{16'b0110, 4, 0, 12, 2, 2, 1});
    #12;
    chk("reset_outputs", {27'd0, x1, x2, busy, done, 1'b0}, 0);
    chk("reset_idx", {27'd0, sym_idx}, 0);
    @(negedge clk);
    rst = 0;
    foreach (vecs[i]) play(vecs[i]);
    @(posedge clk);
    #2;
    start = 1;
    abort = 1;
    @(posedge clk);
    #2;
    start = 0;
    abort = 0;
    chk("abort_beats_start", {31'd0, busy}, 0);
    x1c = 0; x2c = 0;
    repeat (6) @(posedge clk);
    #2;
    chk("abort_idle_quiet", x1c + x2c, 0);
    reset_mid(4, 1);
    reset_mid(6, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
